// File: rtl/counter_ecc_pkg.sv
// rtl/counter_ecc_pkg.sv - Hamming helpers, bounds and syndrome classes; HAMMING_SECDED_EN adds an overall-parity bit
package counter_ecc_pkg;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 16;
    localparam int MAX_P     = 5;
    localparam int MAX_CW    = MAX_WIDTH + MAX_P + 1;

`ifdef HAMMING_SECDED_EN
    localparam int SECDED_BITS = 1;
`else
    localparam int SECDED_BITS = 0;
`endif

    typedef enum logic [1:0] {SYN_NONE, SYN_CORR, SYN_UNCORR} syn_class_e;

    // Smallest p with 2**p >= width+p+1 (descending scan leaves the smallest)
    function automatic int calc_parity_bits(input int width);
        int result;
        result = MAX_P;
        for (int p = MAX_P; p >= 1; p--) begin
            if ((1 << p) >= width + p + 1) result = p;
        end
        return result;
    endfunction

    function automatic int calc_cw(input int width);
        return width + calc_parity_bits(width) + SECDED_BITS;
    endfunction

    // Hamming position (1-based) of data bit idx: the idx-th non power-of-two position
    function automatic int ham_pos(input int idx);
        int n;
        int result;
        n      = 0;
        result = 0;
        for (int pos = 1; pos <= MAX_CW; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (n == idx) result = pos;
                n++;
            end
        end
        return result;
    endfunction

    // Codeword bit (pos-1) holds Hamming position pos; overall parity sits above position width+p
    function automatic logic [MAX_CW-1:0] ham_encode(input logic [MAX_WIDTH-1:0] data, input int width);
        logic [MAX_CW-1:0] cw;
        logic [MAX_CW-1:0] mask;
        int p;
        int n;
        cw = '0;
        p  = calc_parity_bits(width);
        n  = width + p;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width && data[i]) cw = cw | (MAX_CW'(1) << (ham_pos(i) - 1));
        end
        for (int k = 0; k < MAX_P; k++) begin
            if (k < p) begin
                mask = '0;
                for (int pos = 1; pos <= MAX_CW; pos++) begin
                    if (pos <= n && (pos & (1 << k)) != 0) mask = mask | (MAX_CW'(1) << (pos - 1));
                end
                if (^(cw & mask)) cw = cw | (MAX_CW'(1) << ((1 << k) - 1));
            end
        end
        if (SECDED_BITS != 0 && (^cw)) cw = cw | (MAX_CW'(1) << n);
        return cw;
    endfunction

endpackage

// File: rtl/hamming_updown_counter_if.sv
// rtl/hamming_updown_counter_if.sv - control, fault-injection and status bundle of the ECC counter
interface hamming_updown_counter_if #(
    parameter int WIDTH    = 3,
    parameter int ERRCNT_W = 8
);
    localparam int P  = counter_ecc_pkg::calc_parity_bits(WIDTH);
    localparam int CW = counter_ecc_pkg::calc_cw(WIDTH);

    logic                enable;
    logic                up_down;
    logic                load;
    logic [WIDTH-1:0]    load_value;
    logic [CW-1:0]       fault_set;
    logic [CW-1:0]       fault_clr;
    logic [WIDTH-1:0]    count;
    logic [P-1:0]        syndrome;
    logic                err_corr;
    logic                err_uncorr;
    logic                wrap;
    logic [ERRCNT_W-1:0] err_cnt;

    modport master (
        output enable, up_down, load, load_value, fault_set, fault_clr,
        input  count, syndrome, err_corr, err_uncorr, wrap, err_cnt
    );

    modport slave (
        input  enable, up_down, load, load_value, fault_set, fault_clr,
        output count, syndrome, err_corr, err_uncorr, wrap, err_cnt
    );
endinterface

// File: rtl/hamming_decoder.sv
// rtl/hamming_decoder.sv - combinational Hamming decode: codeword -> corrected data, syndrome, class
module hamming_decoder
    import counter_ecc_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [calc_cw(WIDTH)-1:0]          i_code,
    output logic [WIDTH-1:0]                   o_data,
    output logic [calc_parity_bits(WIDTH)-1:0] o_syndrome,
    output syn_class_e                         o_class
);
    localparam int P = calc_parity_bits(WIDTH);
    localparam int N = WIDTH + P;

    logic [P-1:0] w_syn;
    logic         w_in_range;
    logic         w_flip;

    // Syndrome is the XOR of the indices of all set Hamming positions
    always_comb begin
        w_syn = '0;
        for (int pos = 1; pos <= N; pos++) begin
            if (i_code[pos-1]) w_syn = w_syn ^ P'(pos);
        end
    end

    assign w_in_range = (w_syn <= P'(N));
    assign o_syndrome = w_syn;

    // Classify the error; w_flip enables correcting the position named by the syndrome
    always_comb begin
        o_class = SYN_NONE;
        w_flip  = 1'b0;
`ifdef HAMMING_SECDED_EN
        if (^i_code) begin
            if (w_syn == '0) begin
                o_class = SYN_CORR;
            end else if (w_in_range) begin
                o_class = SYN_CORR;
                w_flip  = 1'b1;
            end else begin
                o_class = SYN_UNCORR;
            end
        end else if (w_syn != '0) begin
            o_class = SYN_UNCORR;
        end
`else
        if (w_syn != '0) begin
            if (w_in_range) begin
                o_class = SYN_CORR;
                w_flip  = 1'b1;
            end else begin
                o_class = SYN_UNCORR;
            end
        end
`endif
    end

    // Gather data positions, flipping the one the syndrome points at
    always_comb begin
        o_data = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_data[i] = i_code[ham_pos(i)-1] ^ (w_flip && (w_syn == P'(ham_pos(i))));
        end
    end

endmodule

// File: rtl/hamming_updown_counter.sv
// rtl/hamming_updown_counter.sv - fault-tolerant up/down counter stored as a scrubbed Hamming codeword; HAMMING_SECDED_EN selects SECDED
module hamming_updown_counter
    import counter_ecc_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int RESET_VAL = 0,
    parameter int ERRCNT_W  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    hamming_updown_counter_if.slave bus
);
    localparam int P  = calc_parity_bits(WIDTH);
    localparam int CW = calc_cw(WIDTH);
    localparam logic [WIDTH-1:0] W_MAX      = '1;
    localparam logic [CW-1:0]    RESET_CODE = CW'(ham_encode(MAX_WIDTH'(RESET_VAL), WIDTH));

    logic [CW-1:0]       r_code;
    logic [ERRCNT_W-1:0] r_err_cnt;
    logic [CW-1:0]       w_enc;
    logic [CW-1:0]       w_next_code;
    logic [CW-1:0]       w_fault_code;
    logic [WIDTH-1:0]    w_data;
    logic [WIDTH-1:0]    w_step;
    logic [WIDTH-1:0]    w_next_data;
    logic [P-1:0]        w_syn;
    syn_class_e          w_class;
    logic                w_corr;
    logic                w_uncorr;
    logic                w_step_en;
    logic                w_wrap;

    hamming_decoder #(.WIDTH(WIDTH)) u_decoder (
        .i_code     (r_code),
        .o_data     (w_data),
        .o_syndrome (w_syn),
        .o_class    (w_class)
    );

    assign w_corr    = (w_class == SYN_CORR);
    assign w_uncorr  = (w_class == SYN_UNCORR);
    assign w_step_en = bus.enable & ~bus.load & ~w_uncorr;
    assign w_step    = bus.up_down ? (w_data + 1'b1) : (w_data - 1'b1);
    assign w_wrap    = w_step_en & (bus.up_down ? (w_data == W_MAX) : (w_data == '0));

    // Next data from corrected value: load beats step beats hold
    always_comb begin
        w_next_data = w_data;
        if (bus.load) begin
            w_next_data = bus.load_value;
        end else if (w_step_en) begin
            w_next_data = w_step;
        end
    end

    assign w_enc = CW'(ham_encode(MAX_WIDTH'(w_next_data), WIDTH));
    // A frozen counter keeps its raw codeword so the uncorrectable state stays visible until load
    assign w_next_code  = (w_uncorr & ~bus.load) ? r_code : w_enc;
    assign w_fault_code = (w_next_code | bus.fault_set) & ~(bus.fault_clr & ~bus.fault_set);

    // Codeword register, rewritten every edge so stored errors are scrubbed
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_code <= RESET_CODE;
        end else begin
            r_code <= w_fault_code;
        end
    end

    // Saturating count of edges that saw a corrected error
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (w_corr && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign bus.count      = w_data;
    assign bus.syndrome   = w_syn;
    assign bus.err_corr   = w_corr;
    assign bus.err_uncorr = w_uncorr;
    assign bus.wrap       = w_wrap;
    assign bus.err_cnt    = r_err_cnt;

endmodule
